// File: rtl/color_manager_tx_arbiter_pkg.sv
// Shared constants for the Color Manager TX arbiter: byte/code widths, message
// tags, FSM encodings and the round-robin pointer type.
package color_manager_tx_arbiter_pkg;

    localparam int CM_UART_DATA_WIDTH           = 8;
    localparam int CM_CONFIG_NOTIFICATION_WIDTH = 4;
    localparam int CM_CONFIG_ERROR_WIDTH        = 4;
    localparam int CM_VGA_NOTIFICATION_WIDTH    = 4;

    localparam logic [7:0] CM_TAG_ERR = 8'h45;  // 'E'
    localparam logic [7:0] CM_TAG_CFG = 8'h43;  // 'C'
    localparam logic [7:0] CM_TAG_VGA = 8'h56;  // 'V'

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SEND_TAG  = 2'd1,
        SEND_CODE = 2'd2
    } tx_state_t;

    typedef enum logic {
        RR_CFG = 1'b0,
        RR_VGA = 1'b1
    } rr_ptr_t;

endpackage

// File: rtl/color_manager_event_latch.sv
// One-deep pending slot for a single event source. Holds the zero-extended code
// until granted; a strobe hitting a still-pending, ungranted slot is dropped.
module color_manager_event_latch #(
    parameter int CODE_WIDTH = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [CODE_WIDTH-1:0] code,
    input  logic                  valid,
    input  logic                  grant,
    output logic                  pending,
    output logic [DATA_WIDTH-1:0] held_code,
    output logic                  overrun
);

    // A grant in the same cycle frees the slot, so the new event still fits.
    assign overrun = valid && pending && !grant;

    // NOTE: sequential state is written with <= so every flop samples pre-edge values.
    // NOTE: held_code is reset too; it is only a few flops and keeps X out of TX_Data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending   <= 1'b0;
            held_code <= '0;
        end else if (valid && !overrun) begin
            pending   <= 1'b1;
            held_code <= DATA_WIDTH'(code);
        end else if (grant) begin
            pending   <= 1'b0;
        end
    end

endmodule

// File: rtl/color_manager_tx_arbiter.sv
// Serialises error / configuration / VGA events into two-byte (tag, code)
// messages for the UART TX FIFO. Errors win outright; config and VGA alternate.
module color_manager_tx_arbiter
    import color_manager_tx_arbiter_pkg::*;
#(
    parameter int UART_DATA_WIDTH                    = CM_UART_DATA_WIDTH,
    parameter int CONFIG_NOTIFICATION_WIDTH          = CM_CONFIG_NOTIFICATION_WIDTH,
    parameter int CONFIG_ERROR_WIDTH                 = CM_CONFIG_ERROR_WIDTH,
    parameter int VGA_NOTIFICATION_WIDTH             = CM_VGA_NOTIFICATION_WIDTH,
    parameter logic [UART_DATA_WIDTH-1:0] TAG_ERR    = UART_DATA_WIDTH'(CM_TAG_ERR),
    parameter logic [UART_DATA_WIDTH-1:0] TAG_CFG    = UART_DATA_WIDTH'(CM_TAG_CFG),
    parameter logic [UART_DATA_WIDTH-1:0] TAG_VGA    = UART_DATA_WIDTH'(CM_TAG_VGA)
) (
    input  logic                                 Clk,
    input  logic                                 Rst,
    input  logic [CONFIG_NOTIFICATION_WIDTH-1:0] Config_Notification,
    input  logic                                 Config_Notification_Valid,
    input  logic [CONFIG_ERROR_WIDTH-1:0]        Config_Error,
    input  logic                                 Error_Valid,
    input  logic [VGA_NOTIFICATION_WIDTH-1:0]    VGA_Notification,
    input  logic                                 VGA_Notification_Valid,
    input  logic                                 TX_Full,
    input  logic                                 Clear_Overrun,
    output logic [UART_DATA_WIDTH-1:0]           TX_Data,
    output logic                                 TX_Write,
    output logic                                 Busy,
    output logic [2:0]                           Overrun
);

    tx_state_t state, state_next;
    rr_ptr_t   rr_ptr;

    logic pend_err, pend_cfg, pend_vga;
    logic ovr_err, ovr_cfg, ovr_vga;
    logic gnt_err, gnt_cfg, gnt_vga, any_grant;
    logic [UART_DATA_WIDTH-1:0] code_err, code_cfg, code_vga;
    logic [UART_DATA_WIDTH-1:0] tag_q, code_q;

    color_manager_event_latch #(.CODE_WIDTH(CONFIG_ERROR_WIDTH), .DATA_WIDTH(UART_DATA_WIDTH)) u_err_latch (
        .clk(Clk), .rst_n(Rst), .code(Config_Error), .valid(Error_Valid), .grant(gnt_err),
        .pending(pend_err), .held_code(code_err), .overrun(ovr_err)
    );

    color_manager_event_latch #(.CODE_WIDTH(CONFIG_NOTIFICATION_WIDTH), .DATA_WIDTH(UART_DATA_WIDTH)) u_cfg_latch (
        .clk(Clk), .rst_n(Rst), .code(Config_Notification), .valid(Config_Notification_Valid), .grant(gnt_cfg),
        .pending(pend_cfg), .held_code(code_cfg), .overrun(ovr_cfg)
    );

    color_manager_event_latch #(.CODE_WIDTH(VGA_NOTIFICATION_WIDTH), .DATA_WIDTH(UART_DATA_WIDTH)) u_vga_latch (
        .clk(Clk), .rst_n(Rst), .code(VGA_Notification), .valid(VGA_Notification_Valid), .grant(gnt_vga),
        .pending(pend_vga), .held_code(code_vga), .overrun(ovr_vga)
    );

    // Grants are only issued from IDLE; the pointer breaks config/VGA ties.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        gnt_err = 1'b0;
        gnt_cfg = 1'b0;
        gnt_vga = 1'b0;
        if (state == IDLE) begin
            if (pend_err)
                gnt_err = 1'b1;
            else if (pend_cfg && (rr_ptr == RR_CFG || !pend_vga))
                gnt_cfg = 1'b1;
            else if (pend_vga)
                gnt_vga = 1'b1;
        end
    end

    assign any_grant = gnt_err || gnt_cfg || gnt_vga;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:      if (any_grant) state_next = SEND_TAG;
            SEND_TAG:  if (!TX_Full)  state_next = SEND_CODE;
            SEND_CODE: if (!TX_Full)  state_next = IDLE;
            default:                  state_next = IDLE;
        endcase
    end

    // TX_Data idles on the last code byte since code_q only changes on a grant.
    always_comb begin
        TX_Write = (state != IDLE) && !TX_Full;
        TX_Data  = (state == SEND_TAG) ? tag_q : code_q;
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            tag_q  <= '0;
            code_q <= '0;
            rr_ptr <= RR_CFG;
        end else begin
            if (gnt_err) begin
                tag_q  <= TAG_ERR;
                code_q <= code_err;
            end else if (gnt_cfg) begin
                tag_q  <= TAG_CFG;
                code_q <= code_cfg;
                rr_ptr <= RR_VGA;
            end else if (gnt_vga) begin
                tag_q  <= TAG_VGA;
                code_q <= code_vga;
                rr_ptr <= RR_CFG;
            end
        end
    end

    // New overruns are OR-ed in after the clear, so a simultaneous set wins.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst)
            Overrun <= 3'b000;
        else
            Overrun <= (Overrun & ~{3{Clear_Overrun}}) | {ovr_err, ovr_cfg, ovr_vga};
    end

    assign Busy = (state != IDLE) || pend_err || pend_cfg || pend_vga;

endmodule
